// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scanner: holds a 16-bit value and presents one nibble plus its anode per refresh slot.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic [3:0]  hex_out,
    output logic [3:0]  anode,
    output logic [1:0]  digit_sel
);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [15:0]      disp_q, disp_d;
    logic             tick;
    logic [1:0]       idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIG0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + DIV_W'(1);
        disp_d  = load ? value_in : disp_q;
        state_d = state_q;
        if (tick) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end
    end

    // Outputs come only from registered state, never from the inputs.
    assign idx       = state_q;
    assign digit_sel = idx;
    assign hex_out   = disp_q[4*idx +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [1:0] msd;

    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) msd = 2'(i);
        end
        anode = (idx > msd) ? 4'b1111 : ~(4'b0001 << idx);
    end
`else
    assign anode = ~(4'b0001 << idx);
`endif

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: a behavioural model pushes expected outputs to a queue, compared after each edge.
module tb_seg_scan_controller;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, load;
    logic [15:0] value_in;
    logic [3:0]  hex_out, anode;
    logic [1:0]  digit_sel;

    logic        reset1, load1;
    logic [15:0] value1;
    logic [3:0]  hex1, anode1;
    logic [1:0]  sel1;

    always #5 clk = ~clk;

    seg_scan_controller #(.REFRESH_DIV(DIV), .DIV_W(17)) dut (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in),
        .hex_out(hex_out), .anode(anode), .digit_sel(digit_sel)
    );

    seg_scan_controller #(.REFRESH_DIV(1), .DIV_W(2)) dut1 (
        .clk(clk), .reset(reset1), .load(load1), .value_in(value1),
        .hex_out(hex1), .anode(anode1), .digit_sel(sel1)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] hx;
        logic [1:0] sel;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_cnt    = 0;
    int          m_idx    = 0;
    logic [15:0] m_reg    = 16'h0000;

    function automatic logic [3:0] exp_anode(input int idx, input logic [15:0] r);
        logic [3:0] a;
        a      = 4'hF;
        a[idx] = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 1; i < 4; i++) if (r[4*i +: 4] != 4'h0) msd = i;
            if (idx > msd) a = 4'hF;
        end
`endif
        return a;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic ld, input logic [15:0] v);
        exp_t e;
        bit   t;
        reset    = r;
        load     = ld;
        value_in = v;
        if (r) begin
            m_cnt = 0;
            m_idx = 0;
            m_reg = 16'h0000;
        end else begin
            if (ld) m_reg = v;
            t     = (m_cnt == DIV - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            if (t) m_idx = (m_idx + 1) % 4;
        end
        e.an  = exp_anode(m_idx, m_reg);
        e.hx  = m_reg[4*m_idx +: 4];
        e.sel = 2'(m_idx);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("anode", {12'h0, anode}, {12'h0, e.an});
        check("hex_out", {12'h0, hex_out}, {12'h0, e.hx});
        check("digit_sel", {14'h0, digit_sel}, {14'h0, e.sel});
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        reset1   = 1'b1;
        load1    = 1'b0;
        value1   = 16'h0000;

        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 16'hFFFF);
        check("rst_anode", {12'h0, anode}, 16'h000E);
        check("rst_hex", {12'h0, hex_out}, 16'h0000);
        check("rst_sel", {14'h0, digit_sel}, 16'h0000);

        cycle(1'b0, 1'b1, 16'h1234);
        check("load_hex0", {12'h0, hex_out}, 16'h0004);
        repeat (20) cycle(1'b0, 1'b0, 16'h0);

        for (int k = 0; k < 16 && m_idx != 2; k++) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        check("mid_dig2_hex", {12'h0, hex_out}, 16'h0002);
        cycle(1'b1, 1'b0, 16'h0);
        check("midrst_anode", {12'h0, anode}, 16'h000E);
        check("midrst_hex", {12'h0, hex_out}, 16'h0000);
        check("midrst_sel", {14'h0, digit_sel}, 16'h0000);
        repeat (DIV) cycle(1'b0, 1'b0, 16'h0);
        check("cleared_dig1_sel", {14'h0, digit_sel}, 16'h0001);
        check("cleared_dig1_hex", {12'h0, hex_out}, 16'h0000);

        cycle(1'b0, 1'b1, 16'hABCD);
        check("ld_dig1_hex", {12'h0, hex_out}, 16'h000C);
        check("ld_dig1_anode", {12'h0, anode}, 16'h000D);
        check("ld_dig1_sel", {14'h0, digit_sel}, 16'h0001);
        repeat (6) cycle(1'b0, 1'b0, 16'h0);

        for (int k = 0; k < 20 && !(m_idx == 3 && m_cnt == DIV - 1); k++) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h00F7);
        check("ldtick_hex", {12'h0, hex_out}, 16'h0007);
        check("ldtick_anode", {12'h0, anode}, 16'h000E);
        check("ldtick_sel", {14'h0, digit_sel}, 16'h0000);
        repeat (16) cycle(1'b0, 1'b0, 16'h0);

        cycle(1'b0, 1'b1, 16'h0000);
        repeat (16) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0F00);
        for (int k = 0; k < 20 && m_idx != 3; k++) cycle(1'b0, 1'b0, 16'h0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check("blank_dig3_anode", {12'h0, anode}, 16'h000F);
`else
        check("dig3_anode", {12'h0, anode}, 16'h0007);
`endif
        check("dig3_hex", {12'h0, hex_out}, 16'h0000);
        repeat (16) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h8000);
        repeat (16) cycle(1'b0, 1'b0, 16'h0);

        @(posedge clk);
        #1;
        reset1 = 1'b0;
        check("div1_rst_sel", {14'h0, sel1}, 16'h0000);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("div1_sel", {14'h0, sel1}, 16'((k + 1) % 4));
            check("div1_onehot", 16'($countones(~anode1)), 16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes a 16-bit value across a 4-digit common-anode seven-segment display.
- Holds the value in an internal display register and selects one nibble at a time.
- Drives the selected nibble to the downstream hex-to-7-segment decoder, which turns it into the A–G segment drive.
- Drives the matching active-low anode enable.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz clk gives 1 kHz per digit, 250 Hz full frame); legal range 1 to 2^DIV_W-1.
- DIV_W, 17, width of the refresh divider counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures value_in into the display register.
- value_in  input  16  value to display; digit 0 = value_in[3:0], digit 3 = value_in[15:12].
- hex_out  output  4  nibble for the active digit; feeds the decoder's hex input.
- anode  output  4  active-low digit enables; anode[i]=0 lights digit i.
- digit_sel  output  2  index of the active digit, for debug and LED probing.

Behaviour:
- One clock; reset is synchronous and active-high.
- On the clk edge with reset=1, all of the following apply:
  - divider counter = 0
  - digit index = 0 (state DIG0)
  - display register = 16'h0000
  - load is ignored in that cycle
- Resulting outputs after reset: hex_out=4'h0, anode=4'b1110, digit_sel=2'd0.
- Reset asserted mid-scan or mid-load returns the block to this state at that same edge.
- Display register:
  - load=1 at edge N: register = value_in at edge N.
  - hex_out reflects the new value in the cycle after edge N (one-cycle latency).
  - load held high reloads every cycle.
  - load=0 holds the register.
- Refresh divider:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick=1 in the cycle where count == REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Scan FSM:
  - States: DIG0 → DIG1 → DIG2 → DIG3 → DIG0.
  - The FSM advances only on tick; otherwise it holds.
  - Wrap from DIG3 to DIG0 needs no special handling.
  - Each digit is active for exactly REFRESH_DIV cycles.
- Outputs are decoded from registers only (no input-to-output combinational path):
  - digit_sel = state index.
  - anode = ~(4'b0001 << index).
  - hex_out = register[4*index+3 : 4*index].
- Exactly one anode bit is low at all times, except when blanked by the optional feature.
- Simultaneous load and tick: both take effect at the same edge. The new digit shows the newly loaded value's nibble.
- No illegal states: the 2-bit state encoding covers all four values.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the most significant nonzero nibble of the display register have their anode forced to 1 (off) while active.
  - digit_sel and hex_out behave unchanged.
  - Digit 0 is never blanked, so register 16'h0000 shows a single "0".
  - Example: 16'h00A5 lights digits 1 and 0 only; 16'h0F00 lights digits 2, 1, 0.
- When undefined: all four digits always light, leading zeros included.

Test Plan:
- Reset/scan, REFRESH_DIV=4:
  - Stimulus: reset pulse, load 16'h1234, run 20 cycles.
  - Required: anode goes 1110/0111-cycle pattern 1110, 1101, 1011, 0111 with 4 cycles each.
  - Required: hex_out sequence 4, 3, 2, 1, then wrap to 1110/4.
- Reset values: assert reset mid-DIG2 → next edge gives anode=1110, hex_out=0, digit_sel=0, and the register is cleared.
- Load timing: load 16'hABCD at edge N while in DIG1 → hex_out=C from the cycle after N, with no anode change.
- Simultaneous load and tick at the DIG3→DIG0 edge, value_in=16'h00F7 → digit 0 shows 7 immediately.
- REFRESH_DIV=1: the index changes every cycle, the sequence 0, 1, 2, 3, 0 repeats, and exactly one anode is low every cycle.
- With SEG_LEADING_ZERO_BLANK_EN:
  - 16'h0000 → only digit 0 is lit.
  - 16'h0F00 → digit 3 anode stays 1 during DIG3.
  - 16'h8000 → all four digits are lit.
